// File: rtl/slider_bcd_stepper.sv
// Slider-driven packed-BCD stepper with 2-FF input sync and auto-repeat.
// Lowest held slider wins; wrap or saturate at the range limits.
module slider_bcd_stepper #(
  parameter int NUM_DIGITS    = 4,
  parameter int REPEAT_CYCLES = 32500000,
  parameter bit WRAP_MODE     = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_DIGITS-1:0]   slider,
  input  logic                    dir,
  input  logic                    clear,
  output logic [4*NUM_DIGITS-1:0] bcd,
  output logic                    step_pulse,
  output logic                    limit_pulse
);

  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int TW = $clog2(REPEAT_CYCLES);
  localparam logic [TW-1:0] T_LAST = TW'(REPEAT_CYCLES - 1);

  typedef enum logic {IDLE, HELD} state_e;

  state_e                  state_q;
  logic [NUM_DIGITS-1:0]   sync1_q;
  logic [NUM_DIGITS-1:0]   sync2_q;
  logic [IW-1:0]           sel_q;
  logic [TW-1:0]           timer_q;
  logic [4*NUM_DIGITS-1:0] bcd_q;
  logic                    step_q;
  logic                    limit_q;

  logic                    sel_v;
  logic [IW-1:0]           sel_idx;
  logic                    do_step;
  logic [4*NUM_DIGITS-1:0] bcd_d;
  logic                    ovf_d;
  logic [3:0]              dig;
  logic                    cy;

  always_comb begin
    sel_v   = |sync2_q;
    sel_idx = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      if (sync2_q[i]) sel_idx = IW'(i);
    end
  end

  always_comb begin
    do_step = 1'b0;
    unique case (state_q)
      IDLE: do_step = sel_v;
      HELD: do_step = sel_v &&
                      ((sel_idx != sel_q) || (timer_q == T_LAST));
      default: do_step = 1'b0;
    endcase
    do_step = do_step && !clear;
  end

  // Decimal +/-1 starting at the selected digit; cy out means range exceeded.
  always_comb begin
    bcd_d = bcd_q;
    cy    = 1'b1;
    dig   = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      dig = bcd_q[4*i +: 4];
      if (cy && (i >= int'(sel_idx))) begin
        if (!dir) begin
          cy  = (dig == 4'd9);
          dig = cy ? 4'd0 : dig + 4'd1;
        end else begin
          cy  = (dig == 4'd0);
          dig = cy ? 4'd9 : dig - 4'd1;
        end
      end
      bcd_d[4*i +: 4] = dig;
    end
    ovf_d = cy;
    if (ovf_d && !WRAP_MODE) begin
      bcd_d = dir ? '0 : {NUM_DIGITS{4'h9}};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sync1_q <= '0;
      sync2_q <= '0;
      sel_q   <= '0;
      timer_q <= '0;
      bcd_q   <= '0;
      step_q  <= 1'b0;
      limit_q <= 1'b0;
    end else begin
      sync1_q <= slider;
      sync2_q <= sync1_q;
      step_q  <= do_step;
      limit_q <= do_step && ovf_d;
      if (clear) begin
        bcd_q   <= '0;
        timer_q <= '0;
        sel_q   <= sel_idx;
        state_q <= sel_v ? HELD : IDLE;
      end else begin
        if (do_step) bcd_q <= bcd_d;
        unique case (state_q)
          IDLE: begin
            timer_q <= '0;
            if (sel_v) begin
              state_q <= HELD;
              sel_q   <= sel_idx;
            end
          end
          HELD: begin
            if (!sel_v) begin
              state_q <= IDLE;
              timer_q <= '0;
            end else if (do_step) begin
              timer_q <= '0;
              sel_q   <= sel_idx;
            end else begin
              timer_q <= timer_q + 1'b1;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign bcd         = bcd_q;
  assign step_pulse  = step_q;
  assign limit_pulse = limit_q;

endmodule

// File: tb/tb_slider_bcd_stepper.sv
// Bench for slider_bcd_stepper: wrap and saturate instances side by side
// against an integer-valued reference model.
module tb_slider_bcd_stepper;

  localparam int ND = 4;
  localparam int RC = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [ND-1:0] slider;
  logic          dir;
  logic          clear;
  logic [4*ND-1:0] bcd_w, bcd_s;
  logic          stp_w, stp_s, lim_w, lim_s;

  int n_cmp = 0;
  int n_err = 0;

  // reference model state
  logic [3:0] m_s1, m_s2;
  int         m_cur, m_age;
  int         m_val [2];
  logic       m_ep;
  logic       m_el [2];

  always #5 clk = ~clk;

  slider_bcd_stepper #(.NUM_DIGITS(ND), .REPEAT_CYCLES(RC), .WRAP_MODE(1'b1)) u_wrap (
    .clk(clk), .rst_n(rst_n), .slider(slider), .dir(dir), .clear(clear),
    .bcd(bcd_w), .step_pulse(stp_w), .limit_pulse(lim_w)
  );

  slider_bcd_stepper #(.NUM_DIGITS(ND), .REPEAT_CYCLES(RC), .WRAP_MODE(1'b0)) u_sat (
    .clk(clk), .rst_n(rst_n), .slider(slider), .dir(dir), .clear(clear),
    .bcd(bcd_s), .step_pulse(stp_s), .limit_pulse(lim_s)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r;
    int x;
    x = v;
    r = '0;
    for (int i = 0; i < ND; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic int lowest(input logic [3:0] s);
    for (int i = 0; i < ND; i++) if (s[i]) return i;
    return -1;
  endfunction

  task automatic model_reset();
    m_s1 = '0; m_s2 = '0; m_cur = -1; m_age = 0;
    m_val[0] = 0; m_val[1] = 0;
    m_ep = 0; m_el[0] = 0; m_el[1] = 0;
  endtask

  task automatic model_step(input int k, input logic d);
    int p, v;
    p = 10 ** k;
    m_ep = 1'b1;
    for (int m = 0; m < 2; m++) begin
      v = m_val[m] + (d ? -p : p);
      m_el[m] = (v < 0) || (v >= 10000);
      if (v < 0)           v = (m == 0) ? v + 10000 : 0;
      else if (v >= 10000) v = (m == 0) ? v - 10000 : 9999;
      m_val[m] = v;
    end
  endtask

  task automatic model_edge(input logic [3:0] raw, input logic d, input logic c);
    int sel;
    sel = lowest(m_s2);
    m_ep = 0; m_el[0] = 0; m_el[1] = 0;
    if (c) begin
      m_val[0] = 0; m_val[1] = 0;
      m_age = 0; m_cur = sel;
    end else if (sel < 0) begin
      m_cur = -1; m_age = 0;
    end else if (sel != m_cur) begin
      model_step(sel, d);
      m_cur = sel; m_age = 0;
    end else begin
      m_age++;
      if (m_age == RC) begin
        model_step(sel, d);
        m_age = 0;
      end
    end
    m_s2 = m_s1;
    m_s1 = raw;
  endtask

  task automatic cycle(input logic [3:0] raw, input logic d, input logic c);
    slider = raw; dir = d; clear = c;
    @(posedge clk);
    #1;
    model_edge(raw, d, c);
    chk("w_bcd", 32'(bcd_w), 32'(to_bcd(m_val[0])));
    chk("s_bcd", 32'(bcd_s), 32'(to_bcd(m_val[1])));
    chk("w_step", 32'(stp_w), 32'(m_ep));
    chk("s_step", 32'(stp_s), 32'(m_ep));
    chk("w_lim", 32'(lim_w), 32'(m_el[0]));
    chk("s_lim", 32'(lim_s), 32'(m_el[1]));
  endtask

  task automatic hold(input logic [3:0] mask, input logic d, input int n);
    for (int i = 0; i < n; i++) cycle(mask, d, 1'b0);
  endtask

  task automatic press(input int k, input logic d);
    hold(4'(1 << k), d, 3);
    hold(4'b0, d, 4);
  endtask

  task automatic async_reset();
    #3;
    rst_n = 1'b0;
    #1;
    chk("rst_w_bcd", 32'(bcd_w), 32'h0);
    chk("rst_s_bcd", 32'(bcd_s), 32'h0);
    chk("rst_w_step", 32'(stp_w), 32'h0);
    chk("rst_w_lim", 32'(lim_w), 32'h0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; slider = '0; dir = 1'b0; clear = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_bcd", 32'(bcd_w), 32'h0);
    chk("reset_step", 32'(stp_w), 32'h0);
    chk("reset_lim", 32'(lim_s), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    press(0, 1'b0);
    chk("single_press", 32'(bcd_w), 32'h0001);
    hold(4'b0, 1'b0, 3);

    cycle(4'b0, 1'b0, 1'b1);
    hold(4'b0010, 1'b0, 20);
    hold(4'b0, 1'b0, 4);
    chk("repeat_hold", 32'(bcd_w), 32'h0030);

    cycle(4'b0, 1'b0, 1'b1);
    for (int k = 3; k >= 1; k--)
      for (int n = 0; n < 9; n++) press(k, 1'b0);
    chk("fill_w", 32'(bcd_w), 32'h9990);
    chk("fill_s", 32'(bcd_s), 32'h9990);
    press(1, 1'b0);
    chk("wrap_up", 32'(bcd_w), 32'h0000);
    chk("sat_up", 32'(bcd_s), 32'h9999);
    press(0, 1'b0);
    chk("sat_again", 32'(bcd_s), 32'h9999);

    cycle(4'b0, 1'b0, 1'b1);
    press(2, 1'b0);
    press(0, 1'b1);
    chk("borrow", 32'(bcd_w), 32'h0099);
    press(3, 1'b1);
    chk("wrap_dn", 32'(bcd_w), 32'h9099);
    chk("sat_dn", 32'(bcd_s), 32'h0000);

    cycle(4'b0, 1'b0, 1'b1);
    hold(4'b0101, 1'b0, 12);
    hold(4'b0100, 1'b0, 4);
    hold(4'b0, 1'b0, 4);
    chk("multi_hold", 32'(bcd_w), 32'h0102);

    cycle(4'b0, 1'b0, 1'b1);
    hold(4'b1000, 1'b0, 5);
    cycle(4'b1000, 1'b0, 1'b1);
    chk("clear_hold", 32'(bcd_w), 32'h0);
    hold(4'b1000, 1'b0, 12);
    hold(4'b0, 1'b0, 4);

    hold(4'b1000, 1'b0, 6);
    async_reset();
    hold(4'b1000, 1'b0, 5);
    hold(4'b0, 1'b0, 4);
    chk("post_reset", 32'(bcd_w), 32'h1000);

    for (int r = 0; r < 40; r++) begin
      logic [3:0] mask;
      logic       d;
      int         len;
      mask = ($urandom_range(0, 1) == 0) ? 4'b0 : 4'($urandom_range(1, 15));
      d    = 1'($urandom_range(0, 1));
      len  = $urandom_range(1, 20);
      for (int i = 0; i < len; i++)
        cycle(mask, d, ($urandom_range(0, 29) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
